cutthrough_filter_v2: RTL and testbench

//  Parametrised cut-through AXI-stream market-data filter with zero-latency forwarding.

---
 rtl/cutthrough_pkg.sv | 24 ++
 rtl/cutthrough_filter_v2_symbol_match.sv | 23 ++
 rtl/cutthrough_filter_v2.sv | 157 +++++++++++++++
 tb/tb_cutthrough_filter_v2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cutthrough_pkg.sv
// Shared types and field offsets for the cut-through market-data filter.
// Field offsets are measured down from the MSB of tdata.
package cutthrough_pkg;

    localparam int TYPE_W    = 8;
    localparam int SYM_W     = 32;
    localparam int PRICE_W   = 32;
    localparam int TYPE_OFF  = 0;
    localparam int SYM_OFF   = 8;
    localparam int PRICE_OFF = 0;

    typedef struct packed {
        logic [TYPE_W-1:0]  msg_type;
        logic [SYM_W-1:0]   symbol;
        logic [PRICE_W-1:0] price_q16_16;
    } header_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

endpackage

// File: rtl/cutthrough_filter_v2_symbol_match.sv
// Parallel compare of one 32-bit symbol against the enabled watchlist entries.
module symbol_match
    import cutthrough_pkg::*;
#(
    parameter int NUM_SYMBOLS = 4
) (
    input  logic [SYM_W-1:0]             sym_i,
    input  logic [NUM_SYMBOLS*SYM_W-1:0] cfg_symbol_i,
    input  logic [NUM_SYMBOLS-1:0]       cfg_symbol_en_i,
    output logic                         hit_o
);

    always_comb begin
        // NOTE: default before the loop so every path assigns hit_o and no latch is inferred.
        hit_o = 1'b0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (cfg_symbol_en_i[i] && (cfg_symbol_i[SYM_W*i +: SYM_W] == sym_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cutthrough_filter_v2.sv
// Zero-latency AXI-stream filter: forwards packets whose first beat matches the
// msg-type list and symbol watchlist, sinks the rest, and emits one header per forwarded packet.
module cutthrough_filter_v2
    import cutthrough_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int NUM_SYMBOLS = 4,
    parameter int NUM_TYPES   = 2,
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              slave_tdata,
    input  logic [WIDTH/8-1:0]            slave_byteEnable,
    input  logic                          slave_tvalid,
    input  logic                          slave_tlast,
    output logic                          slave_tready,
    output logic [WIDTH-1:0]              master_tdata,
    output logic [WIDTH/8-1:0]            master_byteEnable,
    output logic                          master_tvalid,
    output logic                          master_tlast,
    input  logic                          master_tready,
    input  logic [NUM_TYPES*TYPE_W-1:0]   cfg_type,
    input  logic [NUM_SYMBOLS*SYM_W-1:0]  cfg_symbol,
    input  logic [NUM_SYMBOLS-1:0]        cfg_symbol_en,
    input  logic                          pulse_ready,
    output logic                          pulse_valid,
    output header_t                       pulse_header,
    output logic [CNT_W-1:0]              stat_pass_cnt,
    output logic [CNT_W-1:0]              stat_drop_cnt,
    output logic [CNT_W-1:0]              stat_pulse_ovf_cnt
);

    state_e              state_q;
    logic                beat1_q;
    logic [TYPE_W-1:0]   stage_type_q;
    logic [SYM_W-1:0]    stage_sym_q;
    logic                pulse_valid_q;
    header_t             pulse_header_q;
    logic [CNT_W-1:0]    pass_cnt_q, drop_cnt_q, ovf_cnt_q;

    logic [TYPE_W-1:0]   msg_type;
    logic [SYM_W-1:0]    symbol;
    logic [PRICE_W-1:0]  price;
    logic                type_hit, sym_hit, match, hs, offer, slot_load;
    logic                pass_evt, drop_evt, ovf_evt;

    assign msg_type = slave_tdata[WIDTH-1-TYPE_OFF  -: TYPE_W];
    assign symbol   = slave_tdata[WIDTH-1-SYM_OFF   -: SYM_W];
    assign price    = slave_tdata[WIDTH-1-PRICE_OFF -: PRICE_W];

    always_comb begin
        type_hit = 1'b0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (cfg_type[TYPE_W*i +: TYPE_W] == msg_type) type_hit = 1'b1;
        end
    end

    symbol_match #(.NUM_SYMBOLS(NUM_SYMBOLS)) u_symbol_match (
        .sym_i           (symbol),
        .cfg_symbol_i    (cfg_symbol),
        .cfg_symbol_en_i (cfg_symbol_en),
        .hit_o           (sym_hit)
    );

    assign match = type_hit & sym_hit;

    assign master_tdata      = slave_tdata;
    assign master_byteEnable = slave_byteEnable;
    assign master_tlast      = slave_tlast;

    // Handshake outputs are combinational so forwarding adds no cycle of latency.
    always_comb begin
        master_tvalid = 1'b0;
        slave_tready  = 1'b1;
        case (state_q)
            IDLE: begin
                master_tvalid = slave_tvalid & match & ~slave_tlast;
                slave_tready  = (match & ~slave_tlast) ? master_tready : 1'b1;
            end
            FWD: begin
                master_tvalid = slave_tvalid;
                slave_tready  = master_tready;
            end
            default: ;
        endcase
    end

    assign hs        = slave_tvalid & slave_tready;
    assign offer     = hs & (state_q == FWD) & beat1_q;
    assign slot_load = offer & (~pulse_valid_q | pulse_ready);
    assign ovf_evt   = offer & pulse_valid_q & ~pulse_ready;
    assign pass_evt  = hs & slave_tlast & (state_q == FWD);
    assign drop_evt  = hs & slave_tlast & ((state_q == IDLE) | (state_q == DROP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat1_q      <= 1'b0;
            stage_type_q <= '0;
            stage_sym_q  <= '0;
        end else if (hs) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            case (state_q)
                IDLE: begin
                    if (!slave_tlast && match) begin
                        state_q      <= FWD;
                        beat1_q      <= 1'b1;
                        stage_type_q <= msg_type;
                        stage_sym_q  <= symbol;
                    end else if (!slave_tlast) begin
                        state_q <= DROP;
                    end
                end
                FWD: begin
                    beat1_q <= 1'b0;
                    if (slave_tlast) state_q <= IDLE;
                end
                default: begin
                    if (slave_tlast) state_q <= IDLE;
                end
            endcase
        end
    end

    // Single-entry pulse slot; a drain in the same cycle frees room for the new header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_valid_q  <= 1'b0;
            pulse_header_q <= '0;
        end else if (slot_load) begin
            pulse_valid_q  <= 1'b1;
            pulse_header_q <= '{msg_type: stage_type_q, symbol: stage_sym_q, price_q16_16: price};
        end else if (pulse_valid_q && pulse_ready) begin
            pulse_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (pass_evt && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            if (drop_evt && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            if (ovf_evt  && (ovf_cnt_q  != '1)) ovf_cnt_q  <= ovf_cnt_q  + CNT_W'(1);
        end
    end

    assign pulse_valid        = pulse_valid_q;
    assign pulse_header       = pulse_header_q;
    assign stat_pass_cnt      = pass_cnt_q;
    assign stat_drop_cnt      = drop_cnt_q;
    assign stat_pulse_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_cutthrough_filter_v2.sv
// Directed bench for cutthrough_filter_v2 with a beat scoreboard and a header scoreboard.
module tb_cutthrough_filter_v2;
    import cutthrough_pkg::*;

    localparam int WIDTH = 64;
    localparam int NS    = 4;
    localparam int NT    = 2;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [WIDTH/8-1:0] be;
        logic               last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     slave_tdata = '0;
    logic [WIDTH/8-1:0]   slave_byteEnable = '0;
    logic                 slave_tvalid = 1'b0;
    logic                 slave_tlast = 1'b0;
    logic                 slave_tready;
    logic [WIDTH-1:0]     master_tdata;
    logic [WIDTH/8-1:0]   master_byteEnable;
    logic                 master_tvalid;
    logic                 master_tlast;
    logic                 master_tready = 1'b1;
    logic [NT*8-1:0]      cfg_type = {8'h51, 8'h54};
    logic [NS*32-1:0]     cfg_symbol = {32'h0, 32'h0, "MSFT", "AAPL"};
    logic [NS-1:0]        cfg_symbol_en = 4'b0001;
    logic                 pulse_ready = 1'b1;
    logic                 pulse_valid;
    header_t              pulse_header;
    logic [CNT_W-1:0]     stat_pass_cnt, stat_drop_cnt, stat_pulse_ovf_cnt;

    beat_t   beat_q[$];
    header_t hdr_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    logic    toggle_mode = 1'b0;

    always #5 clk = ~clk;

    cutthrough_filter_v2 #(
        .WIDTH(WIDTH), .NUM_SYMBOLS(NS), .NUM_TYPES(NT), .CNT_W(CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .slave_tdata        (slave_tdata),
        .slave_byteEnable   (slave_byteEnable),
        .slave_tvalid       (slave_tvalid),
        .slave_tlast        (slave_tlast),
        .slave_tready       (slave_tready),
        .master_tdata       (master_tdata),
        .master_byteEnable  (master_byteEnable),
        .master_tvalid      (master_tvalid),
        .master_tlast       (master_tlast),
        .master_tready      (master_tready),
        .cfg_type           (cfg_type),
        .cfg_symbol         (cfg_symbol),
        .cfg_symbol_en      (cfg_symbol_en),
        .pulse_ready        (pulse_ready),
        .pulse_valid        (pulse_valid),
        .pulse_header       (pulse_header),
        .stat_pass_cnt      (stat_pass_cnt),
        .stat_drop_cnt      (stat_drop_cnt),
        .stat_pulse_ovf_cnt (stat_pulse_ovf_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboards, sampled mid-cycle so the values seen are the ones the next edge commits.
    always @(negedge clk) begin
        if (rst_n) begin
            if (master_tvalid && master_tready) begin
                check("beat_expected", 128'(beat_q.size() > 0), 128'd1);
                if (beat_q.size() > 0) begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("master_tdata", 128'(master_tdata), 128'(e.data));
                    check("master_be",    128'(master_byteEnable), 128'(e.be));
                    check("master_tlast", 128'(master_tlast), 128'(e.last));
                end
            end
            if (pulse_valid && pulse_ready) begin
                check("pulse_expected", 128'(hdr_q.size() > 0), 128'd1);
                if (hdr_q.size() > 0) begin
                    header_t h;
                    h = hdr_q.pop_front();
                    check("pulse_header", 128'(pulse_header), 128'(h));
                end
            end
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [WIDTH/8-1:0] be,
                             input logic last, input logic exp_fwd);
        logic done;
        slave_tdata      = d;
        slave_byteEnable = be;
        slave_tlast      = last;
        slave_tvalid     = 1'b1;
        if (exp_fwd) beat_q.push_back('{data: d, be: be, last: last});
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            master_tready = toggle_mode ? ~master_tready : 1'b1;
            @(negedge clk);
            check("slave_tready", 128'(slave_tready), exp_fwd ? 128'(master_tready) : 128'd1);
            check("master_tvalid", 128'(master_tvalid), 128'(exp_fwd));
            if (slave_tready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("handshake_timeout", 128'(done), 128'd1);
        slave_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] typ, input logic [31:0] sym, input logic [31:0] price,
                            input int nbeats, input logic exp_fwd, input logic push_hdr);
        logic [WIDTH-1:0] d;
        logic [23:0]      pad;
        for (int b = 0; b < nbeats; b++) begin
            pad = 24'($urandom);
            if (b == 0)      d = {typ, sym, pad};
            else if (b == 1) d = {price, 32'($urandom)};
            else             d = {32'($urandom), 32'($urandom)};
            if (push_hdr && b == 1) hdr_q.push_back('{msg_type: typ, symbol: sym, price_q16_16: price});
            send_beat(d, 8'($urandom), (b == nbeats - 1), exp_fwd);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag, input int pass, input int drop, input int ovf);
        check({tag, "_pass"}, 128'(stat_pass_cnt), 128'(pass));
        check({tag, "_drop"}, 128'(stat_drop_cnt), 128'(drop));
        check({tag, "_ovf"},  128'(stat_pulse_ovf_cnt), 128'(ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse_valid", 128'(pulse_valid), 128'd0);
        check("rst_pulse_header", 128'(pulse_header), 128'd0);
        check("rst_master_tvalid", 128'(master_tvalid), 128'd0);
        check_cnts("rst", 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(1);

        // 3-beat matching packet, forwarded in the same cycles with one header.
        send_pkt(8'h51, "AAPL", 32'h00C8_8000, 3, 1'b1, 1'b1);
        idle(3);
        check_cnts("fwd3", 1, 0, 0);

        // Non-matching msg_type: sunk with ready held high.
        send_pkt(8'h41, "AAPL", 32'h1234_5678, 4, 1'b0, 1'b0);
        idle(2);
        check_cnts("drop4", 1, 1, 0);

        // Second accepted type with downstream ready toggling.
        toggle_mode = 1'b1;
        send_pkt(8'h54, "AAPL", 32'h0001_0000, 5, 1'b1, 1'b1);
        toggle_mode   = 1'b0;
        master_tready = 1'b1;
        idle(3);
        check_cnts("toggle", 2, 1, 0);

        // Pulse slot blocked: first header held, second lost.
        pulse_ready = 1'b0;
        send_pkt(8'h51, "AAPL", 32'hAAAA_0001, 2, 1'b1, 1'b1);
        send_pkt(8'h51, "AAPL", 32'hBBBB_0002, 2, 1'b1, 1'b0);
        idle(2);
        check("held_valid", 128'(pulse_valid), 128'd1);
        check("held_header", 128'(pulse_header),
              128'(header_t'{msg_type: 8'h51, symbol: "AAPL", price_q16_16: 32'hAAAA_0001}));
        check_cnts("ovf", 4, 1, 1);
        pulse_ready = 1'b1;
        idle(2);
        check("drained_valid", 128'(pulse_valid), 128'd0);

        // Single-beat packet with a matching header is malformed.
        send_pkt(8'h51, "AAPL", 32'h0, 1, 1'b0, 1'b0);
        idle(2);
        check_cnts("single", 4, 2, 1);
        check("single_no_pulse", 128'(pulse_valid), 128'd0);

        // Watchlist entry present but disabled, then enabled.
        send_pkt(8'h51, "MSFT", 32'h0000_0100, 3, 1'b0, 1'b0);
        cfg_symbol_en = 4'b0011;
        send_pkt(8'h54, "MSFT", 32'h0000_0200, 3, 1'b1, 1'b1);
        cfg_symbol_en = 4'b0001;
        idle(3);
        check_cnts("wl", 5, 3, 1);

        // Reset in the middle of a forwarded packet with a header pending.
        pulse_ready = 1'b0;
        send_beat({8'h51, "AAPL", 24'h0}, 8'hFF, 1'b0, 1'b1);
        send_beat({32'hCAFE_0000, 32'h0}, 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_rst_pulse", 128'(pulse_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pulse_valid", 128'(pulse_valid), 128'd0);
        check("mid_rst_pulse_header", 128'(pulse_header), 128'd0);
        check_cnts("mid_rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        pulse_ready = 1'b1;
        idle(1);
        send_pkt(8'h41, "AAPL", 32'h0, 2, 1'b0, 1'b0);
        send_pkt(8'h51, "AAPL", 32'h0042_0000, 2, 1'b1, 1'b1);
        idle(3);
        check_cnts("post_rst", 1, 1, 0);

        check("beat_q_empty", 128'(beat_q.size()), 128'd0);
        check("hdr_q_empty",  128'(hdr_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
